// File: rtl/mem_stage.sv
// Memory stage: drives a request/ack data-memory port and the memory/writeback register.
// Optional misaligned-access detection is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic [31:0] jump_result,
    input  logic [4:0]  write_reg_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_reg,
    input  logic        branch,
    input  logic        reg_write,
    input  logic [31:0] mem_write_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_mem_data,
    output logic [4:0]  wb_write_reg_addr,
    output logic        wb_mem_reg,
    output logic        wb_reg_write,
    output logic        misalign_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_r;
    logic        mem_op_s;
    logic        misalign_s;
    logic        issue_s;
    logic [31:0] addr_s;
    // Instruction fields captured at issue, retired into the wb register on ack.
    logic [31:0] hold_alu_r;
    logic [4:0]  hold_wra_r;
    logic        hold_mem_reg_r;
    logic        hold_reg_write_r;

    // Decode of the incoming instruction and the combinational stall/branch outputs.
    always_comb begin
        mem_op_s = mem_read | mem_write;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_s = mem_op_s & (alu_result[1:0] != 2'b00);
`else
        misalign_s = 1'b0;
`endif
        addr_s        = {alu_result[31:2], 2'b00};
        issue_s       = mem_op_s & ~misalign_s;
        pc_src        = branch & alu_zero;
        branch_target = jump_result;
        if (state_r == BUSY) begin
            stall = ~dmem_ack;
        end else begin
            stall = issue_s;
        end
    end

    // Access FSM together with the memory port and memory/writeback registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r           <= IDLE;
            dmem_req          <= 1'b0;
            dmem_we           <= 1'b0;
            dmem_addr         <= 32'h0000_0000;
            dmem_wdata        <= 32'h0000_0000;
            hold_alu_r        <= 32'h0000_0000;
            hold_wra_r        <= 5'd0;
            hold_mem_reg_r    <= 1'b0;
            hold_reg_write_r  <= 1'b0;
            wb_alu_result     <= 32'h0000_0000;
            wb_mem_data       <= 32'h0000_0000;
            wb_write_reg_addr <= 5'd0;
            wb_mem_reg        <= 1'b0;
            wb_reg_write      <= 1'b0;
            misalign_err      <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        state_r          <= BUSY;
                        dmem_req         <= 1'b1;
                        dmem_we          <= mem_write;
                        dmem_addr        <= addr_s;
                        dmem_wdata       <= mem_write_data;
                        hold_alu_r       <= alu_result;
                        hold_wra_r       <= write_reg_addr;
                        hold_mem_reg_r   <= mem_reg;
                        hold_reg_write_r <= reg_write;
                        wb_reg_write     <= 1'b0;
                    end else if (misalign_s) begin
                        misalign_err <= 1'b1;
                        wb_reg_write <= 1'b0;
                    end else begin
                        wb_alu_result     <= alu_result;
                        wb_write_reg_addr <= write_reg_addr;
                        wb_mem_reg        <= mem_reg;
                        wb_reg_write      <= reg_write;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state_r           <= IDLE;
                        dmem_req          <= 1'b0;
                        wb_alu_result     <= hold_alu_r;
                        wb_write_reg_addr <= hold_wra_r;
                        wb_mem_reg        <= hold_mem_reg_r;
                        wb_reg_write      <= hold_reg_write_r;
                        // Stores keep the previous load data.
                        if (!dmem_we) begin
                            wb_mem_data <= dmem_rdata;
                        end else begin
                            wb_mem_data <= wb_mem_data;
                        end
                    end else begin
                        wb_reg_write <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    dmem_req     <= 1'b0;
                    wb_reg_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: table-driven non-memory vectors
// plus hand-written load/store/reset/misalign sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result, jump_result, mem_write_data, dmem_rdata;
    logic        alu_zero, mem_read, mem_write, mem_reg, branch, reg_write, dmem_ack;
    logic [4:0]  write_reg_addr;
    logic        dmem_req, dmem_we, stall, pc_src, wb_mem_reg, wb_reg_write, misalign_err;
    logic [31:0] dmem_addr, dmem_wdata, branch_target, wb_alu_result, wb_mem_data;
    logic [4:0]  wb_write_reg_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .alu_zero(alu_zero),
        .jump_result(jump_result), .write_reg_addr(write_reg_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_reg(mem_reg),
        .branch(branch), .reg_write(reg_write), .mem_write_data(mem_write_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .wb_write_reg_addr(wb_write_reg_addr), .wb_mem_reg(wb_mem_reg),
        .wb_reg_write(wb_reg_write), .misalign_err(misalign_err)
    );

    typedef struct {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] jump;
        logic [4:0]  wra;
        logic        br;
        logic        rw;
        logic        mr;
        logic        exp_pc_src;
        logic [31:0] exp_target;
        logic        exp_stall;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nop_inputs();
        alu_result = 32'h0; alu_zero = 1'b0; jump_result = 32'h0; write_reg_addr = 5'd0;
        mem_read = 1'b0; mem_write = 1'b0; mem_reg = 1'b0; branch = 1'b0;
        reg_write = 1'b0; mem_write_data = 32'h0;
    endtask

    initial begin
        int stall_cnt;
        int req_cnt;
        logic [31:0] exp_md;

        vecs[0] = '{32'h1111_1111, 1'b0, 32'h0000_0040, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 1'b0};
        vecs[1] = '{32'h0000_0000, 1'b1, 32'h0000_0040, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0};
        vecs[2] = '{32'hA5A5_A5A5, 1'b1, 32'h0000_1000, 5'd31, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 1'b0};
        vecs[3] = '{32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFF, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0};

        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        nop_inputs();
        #12;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wb_alu", wb_alu_result, 32'h0);
        chk("rst_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Non-memory instructions: single-cycle retire, combinational branch.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            alu_result = vecs[i].alu; alu_zero = vecs[i].zero; jump_result = vecs[i].jump;
            write_reg_addr = vecs[i].wra; branch = vecs[i].br; reg_write = vecs[i].rw;
            mem_reg = vecs[i].mr;
            #1;
            chk($sformatf("v%0d_pc_src", i), {31'd0, pc_src}, {31'd0, vecs[i].exp_pc_src});
            chk($sformatf("v%0d_target", i), branch_target, vecs[i].exp_target);
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
            @(posedge clk); #1;
            chk($sformatf("v%0d_wb_alu", i), wb_alu_result, vecs[i].alu);
            chk($sformatf("v%0d_wb_wra", i), {27'd0, wb_write_reg_addr}, {27'd0, vecs[i].wra});
            chk($sformatf("v%0d_wb_rw", i), {31'd0, wb_reg_write}, {31'd0, vecs[i].rw});
            chk($sformatf("v%0d_wb_mr", i), {31'd0, wb_mem_reg}, {31'd0, vecs[i].mr});
        end

        // Load with three wait-state cycles before the ack.
        @(negedge clk);
        nop_inputs();
        alu_result = 32'h100; mem_read = 1'b1; reg_write = 1'b1; write_reg_addr = 5'd5; mem_reg = 1'b1;
        #1;
        stall_cnt = stall ? 1 : 0;
        req_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            dmem_ack = (c == 3);
            dmem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            if (stall) stall_cnt++;
            if (dmem_req && !dmem_ack) req_cnt++;
            if (c == 0) begin
                chk("ld_addr", dmem_addr, 32'h100);
                chk("ld_we", {31'd0, dmem_we}, 32'd0);
                chk("ld_bubble", {31'd0, wb_reg_write}, 32'd0);
            end
        end
        chk("ld_stall_ack_cycle", {31'd0, stall}, 32'd0);
        chk("ld_stall_cycles", stall_cnt, 32'd4);
        chk("ld_req_cycles", req_cnt, 32'd3);
        @(posedge clk); #1;
        chk("ld_wb_data", wb_mem_data, 32'hDEAD_BEEF);
        chk("ld_wb_wra", {27'd0, wb_write_reg_addr}, 32'd5);
        chk("ld_wb_rw", {31'd0, wb_reg_write}, 32'd1);
        chk("ld_wb_alu", wb_alu_result, 32'h100);
        chk("ld_req_drop", {31'd0, dmem_req}, 32'd0);

        // Store with immediate ack, then read+write treated as a store.
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            dmem_ack = 1'b0;
            nop_inputs();
            alu_result = (s == 0) ? 32'h200 : 32'h204;
            mem_write = 1'b1; mem_read = (s == 1);
            mem_write_data = (s == 0) ? 32'h1234_5678 : 32'h0BAD_CAFE;
            #1;
            chk($sformatf("st%0d_stall_idle", s), {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
            chk($sformatf("st%0d_req", s), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("st%0d_we", s), {31'd0, dmem_we}, 32'd1);
            chk($sformatf("st%0d_addr", s), dmem_addr, (s == 0) ? 32'h200 : 32'h204);
            chk($sformatf("st%0d_wdata", s), dmem_wdata, (s == 0) ? 32'h1234_5678 : 32'h0BAD_CAFE);
            @(negedge clk);
            dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
            #1;
            chk($sformatf("st%0d_stall_ack", s), {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("st%0d_wb_data", s), wb_mem_data, 32'hDEAD_BEEF);
            chk($sformatf("st%0d_done", s), {31'd0, dmem_req}, 32'd0);
        end

        // Reset in the second BUSY cycle aborts the access; later ack ignored.
        @(negedge clk);
        dmem_ack = 1'b0;
        nop_inputs();
        alu_result = 32'h300; mem_read = 1'b1; reg_write = 1'b1; write_reg_addr = 5'd9;
        @(negedge clk);
        @(negedge clk);
        chk("rb_busy_req", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        nop_inputs();
        #1;
        chk("rb_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("rb_addr", dmem_addr, 32'h0);
        chk("rb_wb_data", wb_mem_data, 32'h0);
        chk("rb_wb_alu", wb_alu_result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
        #1;
        chk("rb_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("rb_stray_ack_data", wb_mem_data, 32'h0);
        chk("rb_stray_ack_req", {31'd0, dmem_req}, 32'd0);

        // Misaligned load at 0x102.
        @(negedge clk);
        dmem_ack = 1'b0;
        alu_result = 32'h102; mem_read = 1'b1; reg_write = 1'b1; write_reg_addr = 5'd7;
`ifdef MEM_ALIGN_CHECK_EN
        #1;
        chk("ma_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("ma_req", {31'd0, dmem_req}, 32'd0);
        chk("ma_err", {31'd0, misalign_err}, 32'd1);
        chk("ma_bubble", {31'd0, wb_reg_write}, 32'd0);
        @(negedge clk);
        nop_inputs();
        @(posedge clk); #1;
        chk("ma_err_pulse", {31'd0, misalign_err}, 32'd0);
        exp_md = 32'h0;
`else
        #1;
        chk("ma_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("ma_addr", dmem_addr, 32'h100);
        chk("ma_err", {31'd0, misalign_err}, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h0000_0077;
        @(posedge clk); #1;
        chk("ma_wb_data", wb_mem_data, 32'h77);
        chk("ma_wb_rw", {31'd0, wb_reg_write}, 32'd1);
        exp_md = 32'h77;
`endif

        // Ack while idle must not disturb anything.
        @(negedge clk);
        nop_inputs();
        dmem_ack = 1'b1; dmem_rdata = 32'h9999_9999;
        @(posedge clk); #1;
        chk("idle_ack_data", wb_mem_data, exp_md);
        chk("idle_ack_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
